// File: rtl/wb_shared_port_arbiter_if.sv
// rtl/wb_shared_port_arbiter_if.sv - pipelined Wishbone memory port shared by the arbiter
interface wb_shared_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [3:0]        sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output cyc, stb, we, sel, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  cyc, stb, we, sel, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/wb_shared_port_arbiter.sv
// rtl/wb_shared_port_arbiter.sv - round-robin instr/data arbiter onto one Wishbone port
// One outstanding transfer at a time, with an ack watchdog that aborts to ERR_DATA.
module wb_shared_port_arbiter #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                  clk_core,
  input  logic                  rst_core,

  input  logic                  instr_req_i,
  input  logic [ADDR_W-1:0]     instr_addr_i,
  output logic                  instr_ack_o,
  output logic [DATA_W-1:0]     instr_data_o,

  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_mask_i,
  input  logic [ADDR_W-1:0]     data_addr_i,
  input  logic [DATA_W-1:0]     data_wdata_i,
  output logic                  data_ack_o,
  output logic [DATA_W-1:0]     data_rdata_o,

  wb_shared_port_arbiter_if.master core,

  output logic                  bus_err_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0]   TO_CMP  = (CNT_W + 1)'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              grant_data_q, grant_data_d;
  logic              last_data_q, last_data_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic              instr_ack_q, instr_ack_d;
  logic              data_ack_q, data_ack_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] instr_data_q, instr_data_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic              ack_pending;
  logic              pick_data;
  logic [CNT_W:0]    cnt_inc;
  logic              bus_active;

  // The requester being acked still shows its old req this cycle, so IDLE
  // holds off arbitration until the ack pulse has been seen.
  assign ack_pending = instr_ack_q | data_ack_q;
  assign cnt_inc     = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q      <= S_IDLE;
      grant_data_q <= 1'b0;
      last_data_q  <= 1'b1;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= 4'h0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_q       <= '0;
      instr_ack_q  <= 1'b0;
      data_ack_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      instr_data_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      last_data_q  <= last_data_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_q       <= resp_d;
      instr_ack_q  <= instr_ack_d;
      data_ack_q   <= data_ack_d;
      bus_err_q    <= bus_err_d;
      instr_data_q <= instr_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_data_d = grant_data_q;
    last_data_d  = last_data_q;
    abort_d      = abort_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_d       = resp_q;
    instr_ack_d  = 1'b0;
    data_ack_d   = 1'b0;
    bus_err_d    = 1'b0;
    instr_data_d = instr_data_q;
    data_rdata_d = data_rdata_q;
    pick_data    = data_req_i && (!instr_req_i || !last_data_q);

    case (state_q)
      S_IDLE: begin
        if (!ack_pending && (instr_req_i || data_req_i)) begin
          grant_data_d = pick_data;
          abort_d      = 1'b0;
          if (pick_data) begin
            we_d    = data_we_i;
            sel_d   = data_mask_i;
            addr_d  = data_addr_i;
            wdata_d = data_wdata_i;
          end else begin
            we_d    = 1'b0;
            sel_d   = 4'hF;
            addr_d  = instr_addr_i;
            wdata_d = '0;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (core.ack) begin
          resp_d  = core.rdata;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core.ack) begin
          resp_d  = core.rdata;
          state_d = S_RESP;
        end else if ((TIMEOUT != 0) && (cnt_inc == TO_CMP)) begin
          resp_d  = ERR_DATA;
          abort_d = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
      S_RESP: begin
        last_data_d = grant_data_q;
        bus_err_d   = abort_q;
        if (grant_data_q) begin
          data_ack_d   = 1'b1;
          data_rdata_d = resp_q;
        end else begin
          instr_ack_d  = 1'b1;
          instr_data_d = resp_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus strobes decode straight from the state so an async reset drops them at once.
  always_comb begin
    bus_active = (state_q == S_ISSUE) || (state_q == S_WAIT);
    core.cyc   = bus_active;
    core.stb   = (state_q == S_ISSUE);
    core.we    = bus_active && we_q;
    core.sel   = bus_active ? sel_q : 4'h0;
    core.addr  = bus_active ? addr_q : '0;
    core.wdata = (bus_active && grant_data_q) ? wdata_q : '0;
  end

  assign instr_ack_o  = instr_ack_q;
  assign instr_data_o = instr_data_q;
  assign data_ack_o   = data_ack_q;
  assign data_rdata_o = data_rdata_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_wb_shared_port_arbiter.sv
// tb/tb_wb_shared_port_arbiter.sv - directed self-checking bench for wb_shared_port_arbiter
module tb_wb_shared_port_arbiter;

  logic        clk_core = 1'b0;
  logic        rst_core = 1'b1;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_ack_o;
  logic [31:0] instr_data_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_mask_i = 4'h0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_ack_o;
  logic [31:0] data_rdata_o;
  logic        bus_err_o;

  int n_vec = 0;
  int n_err = 0;

  wb_shared_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) core_bus ();

  wb_shared_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk_core    (clk_core),
    .rst_core    (rst_core),
    .instr_req_i (instr_req_i),
    .instr_addr_i(instr_addr_i),
    .instr_ack_o (instr_ack_o),
    .instr_data_o(instr_data_o),
    .data_req_i  (data_req_i),
    .data_we_i   (data_we_i),
    .data_mask_i (data_mask_i),
    .data_addr_i (data_addr_i),
    .data_wdata_i(data_wdata_i),
    .data_ack_o  (data_ack_o),
    .data_rdata_o(data_rdata_o),
    .core        (core_bus.master),
    .bus_err_o   (bus_err_o)
  );

  always #5 clk_core = ~clk_core;

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".cyc"},   32'(core_bus.cyc), 32'd0);
    chk({tag, ".stb"},   32'(core_bus.stb), 32'd0);
    chk({tag, ".iack"},  32'(instr_ack_o),  32'd0);
    chk({tag, ".dack"},  32'(data_ack_o),   32'd0);
    chk({tag, ".err"},   32'(bus_err_o),    32'd0);
  endtask

  initial begin
    core_bus.ack   = 1'b0;
    core_bus.rdata = '0;

    // reset state
    tick();
    tick();
    chk_quiet("rst");
    chk("rst.idata", instr_data_o, 32'h0);
    chk("rst.ddata", data_rdata_o, 32'h0);
    rst_core = 1'b0;
    tick();

    // 1: lone fetch, bus acks one cycle after stb
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0100;
    tick();
    chk("t1.stb",  32'(core_bus.stb), 32'd1);
    chk("t1.cyc",  32'(core_bus.cyc), 32'd1);
    chk("t1.we",   32'(core_bus.we),  32'd0);
    chk("t1.sel",  32'(core_bus.sel), 32'hF);
    chk("t1.addr", core_bus.addr,     32'h0000_0100);
    tick();
    chk("t1.wait_stb", 32'(core_bus.stb), 32'd0);
    chk("t1.wait_cyc", 32'(core_bus.cyc), 32'd1);
    core_bus.ack   = 1'b1;
    core_bus.rdata = 32'h0000_0013;
    tick();
    core_bus.ack   = 1'b0;
    core_bus.rdata = '0;
    chk("t1.resp_cyc", 32'(core_bus.cyc), 32'd0);
    chk("t1.resp_iack", 32'(instr_ack_o), 32'd0);
    tick();
    chk("t1.iack",  32'(instr_ack_o), 32'd1);
    chk("t1.idata", instr_data_o,     32'h0000_0013);
    chk("t1.dack",  32'(data_ack_o),  32'd0);
    instr_req_i = 1'b0;
    tick();
    chk("t1.iack_once", 32'(instr_ack_o), 32'd0);
    chk("t1.idata_hold", instr_data_o,    32'h0000_0013);

    // 2: both requesters held from reset, bus acks in the strobe cycle
    rst_core = 1'b1;
    tick();
    rst_core = 1'b0;
    core_bus.ack  = 1'b1;
    instr_req_i   = 1'b1;
    instr_addr_i  = 32'h0000_0200;
    data_req_i    = 1'b1;
    data_we_i     = 1'b1;
    data_mask_i   = 4'b0011;
    data_addr_i   = 32'h0000_2004;
    data_wdata_i  = 32'h0000_CAFE;
    for (int g = 0; g < 4; g++) begin
      tick();
      core_bus.rdata = 32'h0000_1000 + 32'(g);
      chk($sformatf("t2.g%0d.stb", g), 32'(core_bus.stb), 32'd1);
      if (g % 2 == 1) begin
        chk($sformatf("t2.g%0d.addr", g),  core_bus.addr,     32'h0000_2004);
        chk($sformatf("t2.g%0d.we", g),    32'(core_bus.we),  32'd1);
        chk($sformatf("t2.g%0d.sel", g),   32'(core_bus.sel), 32'h3);
        chk($sformatf("t2.g%0d.wdata", g), core_bus.wdata,    32'h0000_CAFE);
      end else begin
        chk($sformatf("t2.g%0d.addr", g),  core_bus.addr,     32'h0000_0200);
        chk($sformatf("t2.g%0d.we", g),    32'(core_bus.we),  32'd0);
        chk($sformatf("t2.g%0d.sel", g),   32'(core_bus.sel), 32'hF);
        chk($sformatf("t2.g%0d.wdata", g), core_bus.wdata,    32'h0);
      end
      tick();
      chk($sformatf("t2.g%0d.resp_cyc", g), 32'(core_bus.cyc), 32'd0);
      tick();
      chk($sformatf("t2.g%0d.iack", g), 32'(instr_ack_o), (g % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t2.g%0d.dack", g), 32'(data_ack_o),  (g % 2 == 1) ? 32'd1 : 32'd0);
      if (g % 2 == 1)
        chk($sformatf("t2.g%0d.drd", g), data_rdata_o, 32'h0000_1000 + 32'(g));
      else
        chk($sformatf("t2.g%0d.ird", g), instr_data_o, 32'h0000_1000 + 32'(g));
      chk($sformatf("t2.g%0d.gap_cyc", g), 32'(core_bus.cyc), 32'd0);
      tick();
    end
    instr_req_i    = 1'b0;
    data_req_i     = 1'b0;
    core_bus.ack   = 1'b0;
    core_bus.rdata = '0;
    tick();
    chk_quiet("t2.idle");

    // 3: data load never acked, watchdog aborts after four WAIT cycles
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_mask_i = 4'hF;
    data_addr_i = 32'h0000_3000;
    tick();
    chk("t3.stb",  32'(core_bus.stb), 32'd1);
    chk("t3.addr", core_bus.addr,     32'h0000_3000);
    for (int w = 0; w < 4; w++) begin
      tick();
      chk($sformatf("t3.w%0d.cyc", w), 32'(core_bus.cyc), 32'd1);
      chk($sformatf("t3.w%0d.stb", w), 32'(core_bus.stb), 32'd0);
    end
    tick();
    chk("t3.resp_cyc", 32'(core_bus.cyc), 32'd0);
    chk("t3.resp_dack", 32'(data_ack_o),  32'd0);
    tick();
    chk("t3.dack",  32'(data_ack_o),  32'd1);
    chk("t3.err",   32'(bus_err_o),   32'd1);
    chk("t3.drd",   data_rdata_o,     32'hDEAD_BEEF);
    chk("t3.iack",  32'(instr_ack_o), 32'd0);
    data_req_i = 1'b0;
    tick();
    chk("t3.dack_once", 32'(data_ack_o), 32'd0);
    chk("t3.err_once",  32'(bus_err_o),  32'd0);

    // 4: stray bus ack while idle is ignored
    core_bus.ack   = 1'b1;
    core_bus.rdata = 32'h0BAD_0BAD;
    tick();
    chk_quiet("t4.stray");
    core_bus.ack = 1'b0;
    tick();
    chk_quiet("t4.after");
    chk("t4.drd_hold", data_rdata_o, 32'hDEAD_BEEF);
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0400;
    tick();
    chk("t4.stb",  32'(core_bus.stb), 32'd1);
    chk("t4.addr", core_bus.addr,     32'h0000_0400);
    core_bus.ack   = 1'b1;
    core_bus.rdata = 32'h0000_0055;
    tick();
    core_bus.ack = 1'b0;
    tick();
    chk("t4.iack",  32'(instr_ack_o), 32'd1);
    chk("t4.idata", instr_data_o,     32'h0000_0055);
    instr_req_i = 1'b0;
    tick();

    // 5: reset during WAIT, then the held data request is reissued
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_mask_i = 4'hF;
    data_addr_i = 32'h0000_5000;
    tick();
    chk("t5.stb", 32'(core_bus.stb), 32'd1);
    tick();
    chk("t5.wait_cyc", 32'(core_bus.cyc), 32'd1);
    rst_core = 1'b1;
    #1;
    chk("t5.rst_cyc", 32'(core_bus.cyc), 32'd0);
    chk("t5.rst_stb", 32'(core_bus.stb), 32'd0);
    tick();
    chk_quiet("t5.in_rst");
    tick();
    chk_quiet("t5.in_rst2");
    rst_core = 1'b0;
    tick();
    chk("t5.re_stb",  32'(core_bus.stb), 32'd1);
    chk("t5.re_addr", core_bus.addr,     32'h0000_5000);
    core_bus.ack   = 1'b1;
    core_bus.rdata = 32'h0000_0077;
    tick();
    core_bus.ack = 1'b0;
    tick();
    chk("t5.dack", 32'(data_ack_o), 32'd1);
    chk("t5.drd",  data_rdata_o,    32'h0000_0077);
    chk("t5.err",  32'(bus_err_o),  32'd0);
    data_req_i = 1'b0;
    tick();
    chk_quiet("t5.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
